// File: rtl/wb_pkg.sv
// Shared bus widths, request bundle and arbiter state encoding for the two-master Wishbone arbiter.
package wb_pkg;
   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                cyc;
      logic                stb;
      logic                we;
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
      logic [WB_SEL_W-1:0] sel;
   } wb_req_t;
endpackage

// File: rtl/wb_arb_outst_ctr.sv
// Outstanding-request counter with saturation flag; optional watchdog under WB_ARB_TIMEOUT_EN.
// Zero-latency flags from registered count; counter never underflows on a stray response.
module wb_arb_outst_ctr #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             active,
   input  logic             abort,
   input  logic             accept,
   input  logic             resp,
   output logic [CNT_W-1:0] outst,
   output logic             sat,
   output logic             timeout
);
   assign sat = (outst == CNT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (rst || abort || timeout)
         outst <= '0;
      else if (accept && !resp)
         outst <= outst + CNT_W'(1);
      else if (resp && !accept && (outst != '0))
         outst <= outst - CNT_W'(1);
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WD_W-1:0] wd;
   logic            running;

   assign running = active && (outst != '0);

   // Any bus progress restarts the window, so the limit counts from the last accept/response.
   always_ff @(posedge clk) begin
      if (rst || !running || accept || resp || timeout)
         wd <= '0;
      else
         wd <= wd + WD_W'(1);
   end

   assign timeout = running && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_wd_cfg;
   assign unused_wd_cfg = active ^ (TIMEOUT_CYCLES != 0);
   assign timeout       = 1'b0;
`endif
endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master pipelined Wishbone arbiter: one cycle grant latency, CYC-framed grants, responses to owner only.
// Owner stalls on slave stall or MAX_OUTSTANDING in flight; watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m
   import wb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                m0_wb_cyc_i,
   input  logic                m0_wb_stb_i,
   input  logic                m0_wb_we_i,
   input  logic [WB_ADR_W-1:0] m0_wb_adr_i,
   input  logic [WB_DAT_W-1:0] m0_wb_dat_i,
   input  logic [WB_SEL_W-1:0] m0_wb_sel_i,
   output logic                m0_wb_stall_o,
   output logic                m0_wb_ack_o,
   output logic                m0_wb_err_o,
   output logic [WB_DAT_W-1:0] m0_wb_dat_o,
   input  logic                m1_wb_cyc_i,
   input  logic                m1_wb_stb_i,
   input  logic                m1_wb_we_i,
   input  logic [WB_ADR_W-1:0] m1_wb_adr_i,
   input  logic [WB_DAT_W-1:0] m1_wb_dat_i,
   input  logic [WB_SEL_W-1:0] m1_wb_sel_i,
   output logic                m1_wb_stall_o,
   output logic                m1_wb_ack_o,
   output logic                m1_wb_err_o,
   output logic [WB_DAT_W-1:0] m1_wb_dat_o,
   output logic                s_wb_cyc_o,
   output logic                s_wb_stb_o,
   output logic                s_wb_we_o,
   output logic [WB_ADR_W-1:0] s_wb_adr_o,
   output logic [WB_DAT_W-1:0] s_wb_dat_o,
   output logic [WB_SEL_W-1:0] s_wb_sel_o,
   input  logic                s_wb_stall_i,
   input  logic                s_wb_ack_i,
   input  logic                s_wb_err_i,
   input  logic [WB_DAT_W-1:0] s_wb_dat_i
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   arb_state_t       state, state_nxt;
   logic             last_grant, last_grant_nxt;
   wb_req_t          m0_req, m1_req, own_req;
   logic             in_own, abort, accept, resp, sat, timeout;
   logic             fwd_cyc, fwd_stb, fwd_stall, fwd_ack, fwd_err;
   logic [CNT_W-1:0] outst;

   assign m0_req = '{cyc: m0_wb_cyc_i, stb: m0_wb_stb_i, we: m0_wb_we_i,
                     adr: m0_wb_adr_i, dat: m0_wb_dat_i, sel: m0_wb_sel_i};
   assign m1_req = '{cyc: m1_wb_cyc_i, stb: m1_wb_stb_i, we: m1_wb_we_i,
                     adr: m1_wb_adr_i, dat: m1_wb_dat_i, sel: m1_wb_sel_i};

   assign in_own  = (state == ARB_OWN0) || (state == ARB_OWN1);
   assign own_req = (state == ARB_OWN1) ? m1_req : m0_req;
   assign abort   = in_own && !own_req.cyc;

   // Slave CYC tracks the owner's CYC combinationally so an abort reaches the slave without delay.
   assign fwd_cyc   = own_req.cyc && !timeout;
   assign fwd_stb   = fwd_cyc && own_req.stb && !sat;
   assign fwd_stall = s_wb_stall_i || sat || timeout;
   assign fwd_ack   = fwd_cyc && s_wb_ack_i;
   assign fwd_err   = (fwd_cyc && s_wb_err_i) || timeout;

   assign accept = s_wb_stb_o && !s_wb_stall_i;
   assign resp   = in_own && (s_wb_ack_i || s_wb_err_i);

   wb_arb_outst_ctr #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_outst_ctr (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .active (in_own),
      .abort  (abort),
      .accept (accept),
      .resp   (resp),
      .outst  (outst),
      .sat    (sat),
      .timeout(timeout)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         ARB_IDLE: begin
            if (m0_wb_cyc_i && m1_wb_cyc_i) begin
               state_nxt      = last_grant ? ARB_OWN0 : ARB_OWN1;
               last_grant_nxt = !last_grant;
            end else if (m0_wb_cyc_i) begin
               state_nxt = ARB_OWN0;
            end else if (m1_wb_cyc_i) begin
               state_nxt = ARB_OWN1;
            end
         end
         ARB_OWN0, ARB_OWN1: begin
            if (!own_req.cyc || timeout)
               state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      s_wb_cyc_o    = 1'b0;
      s_wb_stb_o    = 1'b0;
      s_wb_we_o     = 1'b0;
      s_wb_adr_o    = '0;
      s_wb_dat_o    = '0;
      s_wb_sel_o    = '0;
      m0_wb_stall_o = 1'b1;
      m0_wb_ack_o   = 1'b0;
      m0_wb_err_o   = 1'b0;
      m1_wb_stall_o = 1'b1;
      m1_wb_ack_o   = 1'b0;
      m1_wb_err_o   = 1'b0;
      if (in_own) begin
         s_wb_cyc_o = fwd_cyc;
         s_wb_stb_o = fwd_stb;
         s_wb_we_o  = own_req.we;
         s_wb_adr_o = own_req.adr;
         s_wb_dat_o = own_req.dat;
         s_wb_sel_o = own_req.sel;
         if (state == ARB_OWN1) begin
            m1_wb_stall_o = fwd_stall;
            m1_wb_ack_o   = fwd_ack;
            m1_wb_err_o   = fwd_err;
         end else begin
            m0_wb_stall_o = fwd_stall;
            m0_wb_ack_o   = fwd_ack;
            m0_wb_err_o   = fwd_err;
         end
      end
   end

   assign m0_wb_dat_o = s_wb_dat_i;
   assign m1_wb_dat_o = s_wb_dat_i;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m; the watchdog scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter_2m;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i;
   logic [31:0] m0_wb_adr_i, m0_wb_dat_i;
   logic [3:0]  m0_wb_sel_i;
   logic        m0_wb_stall_o, m0_wb_ack_o, m0_wb_err_o;
   logic [31:0] m0_wb_dat_o;
   logic        m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i;
   logic [31:0] m1_wb_adr_i, m1_wb_dat_i;
   logic [3:0]  m1_wb_sel_i;
   logic        m1_wb_stall_o, m1_wb_ack_o, m1_wb_err_o;
   logic [31:0] m1_wb_dat_o;
   logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
   logic [31:0] s_wb_adr_o, s_wb_dat_o;
   logic [3:0]  s_wb_sel_o;
   logic        s_wb_stall_i, s_wb_ack_i, s_wb_err_i;
   logic [31:0] s_wb_dat_i;

   int checks = 0;
   int errors = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_arbiter_2m #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
      .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_sel_i(m0_wb_sel_i),
      .m0_wb_stall_o(m0_wb_stall_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
      .m0_wb_dat_o(m0_wb_dat_o),
      .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
      .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_sel_i(m1_wb_sel_i),
      .m1_wb_stall_o(m1_wb_stall_o), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
      .m1_wb_dat_o(m1_wb_dat_o),
      .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
      .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
      .s_wb_stall_i(s_wb_stall_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i),
      .s_wb_dat_i(s_wb_dat_i)
   );

   // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
   task automatic tick();
      @(posedge wb_clk_i);
      #2;
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b1;
      m0_wb_cyc_i = 0; m0_wb_stb_i = 0; m0_wb_we_i = 0; m0_wb_adr_i = '0; m0_wb_dat_i = '0; m0_wb_sel_i = 4'hF;
      m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0; m1_wb_adr_i = '0; m1_wb_dat_i = '0; m1_wb_sel_i = 4'hF;
      s_wb_stall_i = 0; s_wb_ack_i = 0; s_wb_err_i = 0; s_wb_dat_i = '0;
      tick();
      tick();
      wb_rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_wb_cyc_o); end
      checks++; if (m0_wb_stall_o !== 1'b1) begin errors++; $display("FAIL reset_m0_stall: got %b expected 1", m0_wb_stall_o); end
      checks++; if (m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL reset_m1_stall: got %b expected 1", m1_wb_stall_o); end
      checks++; if ({m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o} !== 4'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0000", {m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o}); end
      // Grant m0, then assert reset while it owns the bus.
      tick(); m0_wb_cyc_i = 1; #1;
      tick(); #1;
      checks++; if (s_wb_cyc_o !== 1'b1) begin errors++; $display("FAIL reset_pre_grant: got %b expected 1", s_wb_cyc_o); end
      wb_rst_i = 1'b1;
      tick(); #1;
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_mid_cycle_cyc: got %b expected 0", s_wb_cyc_o); end
      checks++; if (m0_wb_stall_o !== 1'b1) begin errors++; $display("FAIL reset_mid_cycle_stall: got %b expected 1", m0_wb_stall_o); end
      wb_rst_i = 1'b0; m0_wb_cyc_i = 0;
      tick();
   endtask

   task automatic test_single_read();
      do_reset();
      tick(); m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_adr_i = 32'h0000_0100; #1;
      checks++; if (s_wb_stb_o !== 1'b0) begin errors++; $display("FAIL rd_arb_latency: got %b expected 0", s_wb_stb_o); end
      tick(); #1;
      checks++; if (s_wb_stb_o !== 1'b1) begin errors++; $display("FAIL rd_s_stb: got %b expected 1", s_wb_stb_o); end
      checks++; if (s_wb_adr_o !== 32'h0000_0100) begin errors++; $display("FAIL rd_s_adr: got %h expected 00000100", s_wb_adr_o); end
      checks++; if (m0_wb_stall_o !== 1'b0) begin errors++; $display("FAIL rd_m0_stall: got %b expected 0", m0_wb_stall_o); end
      tick(); m0_wb_stb_i = 0; s_wb_ack_i = 1; s_wb_dat_i = 32'hDEAD_BEEF; #1;
      checks++; if (m0_wb_ack_o !== 1'b1) begin errors++; $display("FAIL rd_m0_ack: got %b expected 1", m0_wb_ack_o); end
      checks++; if (m0_wb_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_dat: got %h expected deadbeef", m0_wb_dat_o); end
      checks++; if (m1_wb_ack_o !== 1'b0) begin errors++; $display("FAIL rd_m1_ack: got %b expected 0", m1_wb_ack_o); end
      tick(); s_wb_ack_i = 0; m0_wb_cyc_i = 0; #1;
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rd_release_cyc: got %b expected 0", s_wb_cyc_o); end
      tick(); #1;
      checks++; if (m0_wb_stall_o !== 1'b1) begin errors++; $display("FAIL rd_idle_stall: got %b expected 1", m0_wb_stall_o); end
   endtask

   task automatic test_tie();
      do_reset();
      tick(); m0_wb_cyc_i = 1; m1_wb_cyc_i = 1; #1;
      tick(); #1;
      checks++; if ({m0_wb_stall_o, m1_wb_stall_o} !== 2'b01) begin errors++; $display("FAIL tie1_owner: got %b expected 01", {m0_wb_stall_o, m1_wb_stall_o}); end
      m0_wb_cyc_i = 0;
      tick(); m0_wb_cyc_i = 1; #1;
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL tie_dead_cycle: got %b expected 0", s_wb_cyc_o); end
      tick(); #1;
      checks++; if ({m0_wb_stall_o, m1_wb_stall_o} !== 2'b10) begin errors++; $display("FAIL tie2_owner: got %b expected 10", {m0_wb_stall_o, m1_wb_stall_o}); end
      m0_wb_cyc_i = 0; m1_wb_cyc_i = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      int acc;
      int acks;
      int fifth;
      int m0_acks;
      do_reset();
      acc = 0; acks = 0; fifth = -1; m0_acks = 0;
      tick(); m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_adr_i = 32'h1000; #1;
      checks++; if (s_wb_stb_o !== 1'b0) begin errors++; $display("FAIL b2b_arb_latency: got %b expected 0", s_wb_stb_o); end
      // Accepts at cycles 1-4 fill the window; slave acks each request 8 cycles after it was accepted.
      for (int n = 1; n <= 19; n++) begin
         tick();
         m1_wb_stb_i = (acc < 6);
         m1_wb_adr_i = 32'h1000 + 32'(4 * acc);
         s_wb_ack_i  = (n == 9 || n == 10 || n == 11 || n == 12 || n == 18 || n == 19);
         s_wb_dat_i  = 32'hA000_0000 + 32'(n);
         #1;
         if (n <= 12) begin
            checks++; if (m1_wb_stall_o !== (n >= 5 && n <= 9)) begin errors++; $display("FAIL b2b_stall_c%0d: got %b expected %b", n, m1_wb_stall_o, (n >= 5 && n <= 9)); end
         end
         if (n == 9) begin
            checks++; if (m1_wb_dat_o !== 32'hA000_0009) begin errors++; $display("FAIL b2b_m1_dat: got %h expected a0000009", m1_wb_dat_o); end
         end
         if (m1_wb_ack_o) acks++;
         if (m0_wb_ack_o) m0_acks++;
         if (m1_wb_stb_i && !m1_wb_stall_o) begin
            acc++;
            if (acc == 5) fifth = n;
         end
      end
      checks++; if (acc !== 6) begin errors++; $display("FAIL b2b_accepts: got %0d expected 6", acc); end
      checks++; if (fifth !== 10) begin errors++; $display("FAIL b2b_fifth_accept_cycle: got %0d expected 10", fifth); end
      checks++; if (acks !== 6) begin errors++; $display("FAIL b2b_m1_acks: got %0d expected 6", acks); end
      checks++; if (m0_acks !== 0) begin errors++; $display("FAIL b2b_m0_acks: got %0d expected 0", m0_acks); end
      tick(); s_wb_ack_i = 0; m1_wb_cyc_i = 0; m1_wb_stb_i = 0; #1;
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_release_cyc: got %b expected 0", s_wb_cyc_o); end
      tick(); #1;
      checks++; if (m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL b2b_idle_stall: got %b expected 1", m1_wb_stall_o); end
   endtask

   task automatic test_abort();
      do_reset();
      tick();
      m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_adr_i = 32'h300;
      m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_adr_i = 32'h200;
      #1;
      tick(); #1;
      checks++; if (s_wb_adr_o !== 32'h300) begin errors++; $display("FAIL abort_m0_owner: got %h expected 00000300", s_wb_adr_o); end
      tick(); m0_wb_adr_i = 32'h304; #1;
      tick(); m0_wb_cyc_i = 0; m0_wb_stb_i = 0; s_wb_ack_i = 1; #1;
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL abort_s_cyc_same_cycle: got %b expected 0", s_wb_cyc_o); end
      checks++; if ({m0_wb_ack_o, m1_wb_ack_o} !== 2'b00) begin errors++; $display("FAIL abort_late_ack0: got %b expected 00", {m0_wb_ack_o, m1_wb_ack_o}); end
      tick(); #1;
      checks++; if ({m0_wb_ack_o, m1_wb_ack_o} !== 2'b00) begin errors++; $display("FAIL abort_late_ack1: got %b expected 00", {m0_wb_ack_o, m1_wb_ack_o}); end
      checks++; if (m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL abort_dead_cycle: got %b expected 1", m1_wb_stall_o); end
      tick(); s_wb_ack_i = 0; #1;
      checks++; if ({s_wb_cyc_o, s_wb_stb_o} !== 2'b11 || s_wb_adr_o !== 32'h200) begin errors++; $display("FAIL abort_m1_grant: got cyc/stb %b adr %h expected 11 00000200", {s_wb_cyc_o, s_wb_stb_o}, s_wb_adr_o); end
      // A cleared counter lets m1 issue four requests before saturating.
      for (int n = 0; n < 4; n++) begin
         if (n > 0) begin tick(); #1; end
         checks++; if (m1_wb_stall_o !== 1'b0) begin errors++; $display("FAIL abort_counter_cleared_%0d: got %b expected 0", n, m1_wb_stall_o); end
      end
      tick(); #1;
      checks++; if (m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL abort_m1_saturate: got %b expected 1", m1_wb_stall_o); end
      m1_wb_cyc_i = 0; m1_wb_stb_i = 0;
      tick();
   endtask

   task automatic test_accept_ack_same();
      do_reset();
      tick(); m0_wb_cyc_i = 1; m0_wb_stb_i = 1; #1;
      tick(); #1;
      tick(); s_wb_ack_i = 1; #1;
      checks++; if (m0_wb_ack_o !== 1'b1 || m0_wb_stall_o !== 1'b0) begin errors++; $display("FAIL same_cycle_ack_accept: got ack %b stall %b expected 1 0", m0_wb_ack_o, m0_wb_stall_o); end
      tick(); s_wb_ack_i = 0; #1;
      tick(); #1;
      tick(); #1;
      checks++; if (m0_wb_stall_o !== 1'b0) begin errors++; $display("FAIL same_cycle_outst3: got %b expected 0", m0_wb_stall_o); end
      tick(); #1;
      checks++; if (m0_wb_stall_o !== 1'b1) begin errors++; $display("FAIL same_cycle_outst4: got %b expected 1", m0_wb_stall_o); end
      m0_wb_cyc_i = 0; m0_wb_stb_i = 0;
      tick();
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int early_err;
      do_reset();
      early_err = 0;
      tick(); m0_wb_cyc_i = 1; m0_wb_stb_i = 1; #1;
      tick(); #1;
      for (int n = 2; n <= 16; n++) begin
         tick(); m0_wb_stb_i = 0; #1;
         if (m0_wb_err_o) early_err++;
      end
      checks++; if (early_err !== 0) begin errors++; $display("FAIL timeout_early_err: got %0d expected 0", early_err); end
      tick(); #1;
      checks++; if ({m0_wb_err_o, s_wb_cyc_o} !== 2'b10) begin errors++; $display("FAIL timeout_pulse: got err/cyc %b expected 10", {m0_wb_err_o, s_wb_cyc_o}); end
      tick(); #1;
      checks++; if ({m0_wb_err_o, s_wb_cyc_o, m0_wb_stall_o} !== 3'b001) begin errors++; $display("FAIL timeout_idle: got err/cyc/stall %b expected 001", {m0_wb_err_o, s_wb_cyc_o, m0_wb_stall_o}); end
      m0_wb_cyc_i = 0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_back_to_back();
      test_abort();
      test_accept_ack_same();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
